dispensador_troco: RTL
======================

// Module: dispensador_troco
// PURPOSE
//  Change-coin payout unit: the dispensing end of the vending machine's change path.
//  Accepts a packed per-denomination coin count (same packing as moedas_troco),
//  pays coins out one at a time via solenoid pulses, confirms each coin with an
//  exit sensor, and tracks its own coin stock. Reports completion, status and amount paid.
// PARAMETERS
//  PULSE_CYCLES    4   ejetar_* high time per coin, in clock cycles (>=1)
//  GAP_CYCLES      2   idle cycles between coins, all ejetar_* low (>=1)
//  TIMEOUT_CYCLES  64  WAIT cycles without sensor before jam is declared (>=1)
// PORTS
//  clock           in   1   rising-edge clock
//  reset_n         in   1   synchronous reset, active-low
//  req_valid       in   1   payout request valid
//  req_moedas      in   24  [7:0]=R$0,25 count, [15:8]=R$0,50, [23:16]=R$1,00
//  req_ready       out  1   high only in IDLE; request accepted when req_valid & req_ready
//  recarga_valid   in   1   stock reload strobe (honoured only in IDLE)
//  recarga_moedas  in   24  coins added to stock, same packing
//  sensor_moeda    in   1   exit-sensor pulse, one per coin dropped
//  ejetar_25/50/100 out 1   solenoid drive per denomination (at most one high)
//  pronto          out  1   one-cycle completion pulse
//  erro            out  2   0=ok, 1=insufficient stock, 2=jam timeout; valid with pronto, held to next accept
//  estoque         out  24  current coin stock, same packing
//  restante        out  24  coins still owed on current/last request
//  valor_pago      out  16  cents paid on current/last request
// BEHAVIOUR
//  Reset (reset_n low at edge): state IDLE; all outputs 0 (estoque, restante, valor_pago, erro,
//   ejetar_*, pronto); counters cleared. Applies mid-operation too; no partial payout resumes.
//  IDLE: req_ready=1. Accept -> restante<=req_moedas, valor_pago<=0, erro<=0, go CHECK.
//   recarga_valid in IDLE with no accept that cycle: each estoque field += recarga field,
//   saturating at 255. recarga coincident with accept, or outside IDLE: ignored.
//  CHECK (1 cycle): any restante field > estoque field -> erro=1, go DONE, nothing paid.
//   restante==0 -> DONE, erro=0. Else -> EJECT.
//  EJECT: denomination = highest nonzero restante field (100, then 50, then 25). Its ejetar_*
//   high exactly PULSE_CYCLES cycles, first high 2 cycles after the accept edge for the 1st coin.
//   Then: coin already confirmed -> GAP; else WAIT.
//  WAIT: ejetar_* low; counts cycles; sensor -> GAP; TIMEOUT_CYCLES cycles with no sensor ->
//   erro=2, DONE (restante/estoque keep the unpaid coin).
//  Sensor: sampled in EJECT and WAIT; first pulse per coin confirms it: on that edge that field
//   of restante -=1, of estoque -=1, valor_pago += 25/50/100. Further pulses for the same coin,
//   and pulses in IDLE/CHECK/GAP/DONE, ignored.
//  GAP: GAP_CYCLES cycles, ejetar_* low; then restante==0 -> DONE, else EJECT (next coin).
//  DONE: pronto=1 for one cycle, then IDLE. Zero request: pronto 2 cycles after accept.
//  Arithmetic: valor_pago 16 bit, max 255*175=44625, no overflow. No field underflows
//   (CHECK guarantees stock; restante decrements only while nonzero).
// TESTING
//  1. reset; recarga 24'h020304; req 24'h010102, sensor 2 cycles after each ejetar rise ->
//     ejects 100,50,25,25 each 4 cycles wide, 2-cycle gaps; pronto, erro=0, valor_pago=200,
//     estoque=24'h010202, restante=0.
//  2. stock 24'h000001; req 24'h000002 -> no ejetar, pronto 2 cycles after accept, erro=1,
//     estoque unchanged, restante=24'h000002.
//  3. stock 24'h000100; req 24'h000100, no sensor -> ejetar_50 4 cycles, pronto after 64 WAIT
//     cycles, erro=2, restante=24'h000100, estoque=24'h000100.
//  4. 25c stock 250 + recarga 10 -> 255; recarga during EJECT ignored; recarga with accepted
//     req in same cycle ignored.
//  5. sensor during EJECT pulse (twice) -> coin counted once, no WAIT, straight to GAP.
//  6. reset_n low during ejetar_100 -> next edge: all outputs 0, req_ready=1 once released.

Source files
------------

// File: rtl/dispensador_troco.sv
// dispensador_troco: change-coin payout unit.
// Pays out a packed per-denomination coin request one coin at a time,
// using solenoid pulses. Each coin is confirmed by the exit sensor.
// The unit keeps its own stock and reports the status and amount paid.
// Packing of every 24-bit coin vector: [7:0]=R$0,25 [15:8]=R$0,50 [23:16]=R$1,00.
module dispensador_troco #(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [23:0] req_moedas,
  output logic        req_ready,
  input  logic        recarga_valid,
  input  logic [23:0] recarga_moedas,
  input  logic        sensor_moeda,
  output logic        ejetar_25,
  output logic        ejetar_50,
  output logic        ejetar_100,
  output logic        pronto,
  output logic [1:0]  erro,
  output logic [23:0] estoque,
  output logic [23:0] restante,
  output logic [15:0] valor_pago
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_EJECT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0]  ERR_OK      = 2'd0;
  localparam logic [1:0]  ERR_STOCK   = 2'd1;
  localparam logic [1:0]  ERR_JAM     = 2'd2;
  localparam logic [1:0]  DEN_25      = 2'd0;
  localparam logic [1:0]  DEN_50      = 2'd1;
  localparam logic [1:0]  DEN_100     = 2'd2;
  localparam logic [15:0] PULSE_LAST  = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  // 8-bit add that clamps at 255 instead of wrapping
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[8]) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
  endfunction

  // Highest-value denomination still owed (100, then 50, then 25)
  function automatic logic [1:0] pick_den(input logic [23:0] owed);
    if (owed[23:16] != 8'd0) begin
      return DEN_100;
    end else if (owed[15:8] != 8'd0) begin
      return DEN_50;
    end else begin
      return DEN_25;
    end
  endfunction

  // One coin of the given denomination, in packed form
  function automatic logic [23:0] den_unit(input logic [1:0] den);
    case (den)
      DEN_100: return 24'h010000;
      DEN_50:  return 24'h000100;
      default: return 24'h000001;
    endcase
  endfunction

  // Value in cents of one coin of the given denomination
  function automatic logic [15:0] den_cents(input logic [1:0] den);
    case (den)
      DEN_100: return 16'd100;
      DEN_50:  return 16'd50;
      default: return 16'd25;
    endcase
  endfunction

  // True when any requested field exceeds the matching stock field
  function automatic logic stock_short(input logic [23:0] need, input logic [23:0] have);
    return (need[7:0] > have[7:0]) || (need[15:8] > have[15:8]) ||
           (need[23:16] > have[23:16]);
  endfunction

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [1:0]  den_r;
  logic        conf_r;
  logic [23:0] estoque_r;
  logic [23:0] restante_r;
  logic [15:0] valor_pago_r;
  logic [1:0]  erro_r;
  logic        pronto_r;
  logic        ejetar_25_r;
  logic        ejetar_50_r;
  logic        ejetar_100_r;

  logic [1:0]  next_den_s;
  logic [23:0] unit_s;
  logic [15:0] cents_s;
  logic        short_s;
  logic        confirm_s;

  assign next_den_s = pick_den(restante_r);
  assign unit_s     = den_unit(den_r);
  assign cents_s    = den_cents(den_r);
  assign short_s    = stock_short(restante_r, estoque_r);
  // Only the first sensor pulse of a coin counts, and only while ejecting or waiting
  assign confirm_s  = sensor_moeda &&
                      (((state_r == ST_EJECT) && !conf_r) || (state_r == ST_WAIT));

  assign req_ready  = (state_r == ST_IDLE);
  assign ejetar_25  = ejetar_25_r;
  assign ejetar_50  = ejetar_50_r;
  assign ejetar_100 = ejetar_100_r;
  assign pronto     = pronto_r;
  assign erro       = erro_r;
  assign estoque    = estoque_r;
  assign restante   = restante_r;
  assign valor_pago = valor_pago_r;

  // Payout FSM: outputs are registered and change on entry to each state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 16'd0;
      den_r        <= DEN_25;
      conf_r       <= 1'b0;
      estoque_r    <= 24'd0;
      restante_r   <= 24'd0;
      valor_pago_r <= 16'd0;
      erro_r       <= ERR_OK;
      pronto_r     <= 1'b0;
      ejetar_25_r  <= 1'b0;
      ejetar_50_r  <= 1'b0;
      ejetar_100_r <= 1'b0;
    end else begin
      pronto_r <= 1'b0;
      if (confirm_s) begin
        restante_r   <= restante_r - unit_s;
        estoque_r    <= estoque_r - unit_s;
        valor_pago_r <= valor_pago_r + cents_s;
        conf_r       <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            restante_r   <= req_moedas;
            valor_pago_r <= 16'd0;
            erro_r       <= ERR_OK;
            state_r      <= ST_CHECK;
          end else if (recarga_valid) begin
            estoque_r <= {sat_add8(estoque_r[23:16], recarga_moedas[23:16]),
                          sat_add8(estoque_r[15:8],  recarga_moedas[15:8]),
                          sat_add8(estoque_r[7:0],   recarga_moedas[7:0])};
          end
        end
        ST_CHECK: begin
          if (short_s) begin
            erro_r   <= ERR_STOCK;
            pronto_r <= 1'b1;
            state_r  <= ST_DONE;
          end else if (restante_r == 24'd0) begin
            pronto_r <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            den_r        <= next_den_s;
            ejetar_25_r  <= (next_den_s == DEN_25);
            ejetar_50_r  <= (next_den_s == DEN_50);
            ejetar_100_r <= (next_den_s == DEN_100);
            conf_r       <= 1'b0;
            cnt_r        <= 16'd0;
            state_r      <= ST_EJECT;
          end
        end
        ST_EJECT: begin
          if (cnt_r == PULSE_LAST) begin
            ejetar_25_r  <= 1'b0;
            ejetar_50_r  <= 1'b0;
            ejetar_100_r <= 1'b0;
            cnt_r        <= 16'd0;
            state_r      <= (conf_r || sensor_moeda) ? ST_GAP : ST_WAIT;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_WAIT: begin
          if (sensor_moeda) begin
            cnt_r   <= 16'd0;
            state_r <= ST_GAP;
          end else if (cnt_r == TMO_LAST) begin
            erro_r   <= ERR_JAM;
            pronto_r <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r <= 16'd0;
            if (restante_r == 24'd0) begin
              pronto_r <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              den_r        <= next_den_s;
              ejetar_25_r  <= (next_den_s == DEN_25);
              ejetar_50_r  <= (next_den_s == DEN_50);
              ejetar_100_r <= (next_den_s == DEN_100);
              conf_r       <= 1'b0;
              state_r      <= ST_EJECT;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
